// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, default datapath widths, and the
// term-counter width rule used by mac_accumulator.
package mac_pkg;

   // IDLE: no term accepted yet; ACC: at least one term summed; DONE: result held.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_PROD_W = 8;   // matches the 4x4 multiplier output
   localparam int DEF_ACC_W  = 16;

   // The counter must be able to hold N_TERMS itself, not just N_TERMS-1.
   function automatic int cnt_width(input int n_terms);
      return $clog2(n_terms + 1);
   endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: acc + zero-extended product, with carry out.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Build option: MAC_SAT_EN clamps the sum to all-ones on carry out;
// without it the sum wraps modulo 2^ACC_W.
// Ports:
//   a     in  ACC_W   running sum
//   b     in  PROD_W  unsigned product, zero-extended
//   sum   out ACC_W   wrapped or clamped sum
//   carry out 1       carry out of the ACC_W+1 bit add
module mac_sat_add #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] full;

   always_comb begin
      full  = {1'b0, a} + (ACC_W+1)'(b);
      carry = full[ACC_W];
`ifdef MAC_SAT_EN
      // Once clamped, later non-zero terms carry again and re-clamp,
      // so the value holds at the maximum for the rest of the group.
      sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
      sum = full[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/mac_accumulator.sv
// Sums a group of N_TERMS products (or fewer, ended by prod_last) into one result.
// Latency: acc_valid rises the cycle after the final term is accepted.
// Backpressure: prod_ready is low while a result waits in DONE; no bypass, so >=1 bubble.
//
// Build option: MAC_SAT_EN (see mac_sat_add) selects clamping instead of wrapping.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   prod_valid/ready      product handshake; prod, prod_last sampled on accept
//   acc_valid/ready       result handshake
//   acc                   running sum, meaningful while acc_valid=1
//   acc_ovf               sticky carry-out flag for the current group
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W  = DEF_PROD_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int N_TERMS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_last,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc,
   output logic              acc_ovf
);

   localparam int CNT_W = cnt_width(N_TERMS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [ACC_W-1:0] acc_q, acc_nxt, sum;
   logic             ovf_q, ovf_nxt, carry;
   logic             accept, final_term;

   mac_sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .a     (acc_q),
      .b     (prod),
      .sum   (sum),
      .carry (carry)
   );

   assign prod_ready = (state != DONE);
   assign acc_valid  = (state == DONE);
   assign acc        = acc_q;
   assign acc_ovf    = ovf_q;
   assign accept     = prod_valid && prod_ready;
   assign final_term = prod_last || (count == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         acc_q <= acc_nxt;
         ovf_q <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      acc_nxt   = acc_q;
      ovf_nxt   = ovf_q;
      case (state)
         IDLE, ACC: begin
            if (accept) begin
               acc_nxt   = sum;
               ovf_nxt   = ovf_q | carry;
               count_nxt = count + CNT_W'(1);
               state_nxt = final_term ? DONE : ACC;
            end
         end
         DONE: begin
            if (acc_ready) begin
               state_nxt = IDLE;
               count_nxt = '0;
               acc_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances share clk/rst.
//   d=0: default (ACC_W=16, N_TERMS=4); d=1: ACC_W=8; d=2: N_TERMS=1.
// Stimulus pushes expected results; a negedge monitor pops on each result handshake.
module tb_mac_accumulator;

   typedef struct {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pv [3];
   logic       pr [3];
   logic [7:0] pd [3];
   logic       pl [3];
   logic       av [3];
   logic       ar [3];
   logic       ov [3];
   logic [15:0] acc0, acc2;
   logic [7:0]  acc1;

   exp_t q0[$], q1[$], q2[$];
   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   mac_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) dut0 (
      .clk(clk), .rst(rst), .prod_valid(pv[0]), .prod_ready(pr[0]), .prod(pd[0]),
      .prod_last(pl[0]), .acc_valid(av[0]), .acc_ready(ar[0]), .acc(acc0), .acc_ovf(ov[0]));

   mac_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(4)) dut1 (
      .clk(clk), .rst(rst), .prod_valid(pv[1]), .prod_ready(pr[1]), .prod(pd[1]),
      .prod_last(pl[1]), .acc_valid(av[1]), .acc_ready(ar[1]), .acc(acc1), .acc_ovf(ov[1]));

   mac_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(1)) dut2 (
      .clk(clk), .rst(rst), .prod_valid(pv[2]), .prod_ready(pr[2]), .prod(pd[2]),
      .prod_last(pl[2]), .acc_valid(av[2]), .acc_ready(ar[2]), .acc(acc2), .acc_ovf(ov[2]));

   function automatic logic [15:0] get_acc(input int d);
      case (d)
         0:       return acc0;
         1:       return {8'd0, acc1};
         default: return acc2;
      endcase
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      tests_run++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [15:0] a, input logic o);
      exp_t e;
      e.acc = a;
      e.ovf = o;
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: a result handshake completes at the next posedge when valid&ready now.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            if (av[d] && ar[d]) begin
               exp_t e;
               int   n;
               case (d)
                  0:       n = q0.size();
                  1:       n = q1.size();
                  default: n = q2.size();
               endcase
               if (n == 0) begin
                  chk($sformatf("unexpected_result_d%0d", d), 1, 0);
               end else begin
                  case (d)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  chk($sformatf("result_acc_d%0d", d), get_acc(d), e.acc);
                  chk($sformatf("result_ovf_d%0d", d), ov[d], e.ovf);
               end
            end
         end
      end
   end

   // Present a product and return #1 after the edge that accepts it; valid stays high.
   task automatic send(input int d, input logic [7:0] p, input logic last);
      int waited = 0;
      pv[d] = 1'b1;
      pd[d] = p;
      pl[d] = last;
      while (!pr[d] && waited < 50) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!pr[d]) chk($sformatf("send_timeout_d%0d", d), 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d, input int cycles);
      pv[d] = 1'b0;
      pl[d] = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         pv[d] = 1'b0;
         pl[d] = 1'b0;
         pd[d] = 8'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) ar[d] = 1'b1;
      do_reset();

      // Reset state
      chk("reset_acc_valid", av[0], 0);
      chk("reset_prod_ready", pr[0], 1);
      chk("reset_acc", acc0, 0);
      chk("reset_acc_ovf", ov[0], 0);

      // 1: 10,20,30,40 back-to-back -> 100 the cycle after the 4th accept
      push(0, 16'd100, 1'b0);
      send(0, 8'd10, 1'b0);
      send(0, 8'd20, 1'b0);
      send(0, 8'd30, 1'b0);
      chk("t1_not_done_after_3", av[0], 0);
      send(0, 8'd40, 1'b0);
      chk("t1_valid_latency", av[0], 1);
      chk("t1_acc", acc0, 100);
      chk("t1_prod_ready_low", pr[0], 0);
      idle(0, 1);

      // 2: 225,225 last -> 450; next group of four counts from zero
      push(0, 16'd450, 1'b0);
      send(0, 8'd225, 1'b0);
      send(0, 8'd225, 1'b1);
      chk("t2_valid", av[0], 1);
      chk("t2_acc", acc0, 450);
      push(0, 16'd10, 1'b0);
      send(0, 8'd1, 1'b0);
      send(0, 8'd2, 1'b0);
      send(0, 8'd3, 1'b0);
      chk("t2_count_restart", av[0], 0);
      send(0, 8'd4, 1'b0);
      chk("t2_group2_valid", av[0], 1);
      idle(0, 1);

      // 3: result held 5 cycles with a product waiting
      ar[0] = 1'b0;
      push(0, 16'd20, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd5, 1'b0);
      push(0, 16'd9, 1'b0);
      pv[0] = 1'b1;
      pd[0] = 8'd9;
      pl[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_prod_ready_held", pr[0], 0);
         chk("t3_acc_held", acc0, 20);
         chk("t3_valid_held", av[0], 1);
         @(posedge clk);
         #1;
      end
      ar[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("t3_idle_after_release", av[0], 0);
      chk("t3_ready_after_release", pr[0], 1);
      @(posedge clk);
      #1;
      pv[0] = 1'b0;
      pl[0] = 1'b0;
      chk("t3_next_accepted", av[0], 1);
      chk("t3_next_acc", acc0, 9);
      idle(0, 1);

      // 4: ACC_W=8, 200+100 overflows
`ifdef MAC_SAT_EN
      push(1, 16'd255, 1'b1);
`else
      push(1, 16'd44, 1'b1);
`endif
      send(1, 8'd200, 1'b0);
      chk("t4_no_ovf_yet", ov[1], 0);
      send(1, 8'd100, 1'b1);
      chk("t4_ovf", ov[1], 1);
      idle(1, 2);
      chk("t4_ovf_cleared", ov[1], 0);

      // 5: reset mid-group discards the partial sum
      send(0, 8'd1, 1'b0);
      send(0, 8'd2, 1'b0);
      idle(0, 1);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         chk("t5_no_valid_after_rst", av[0], 0);
         @(posedge clk);
         #1;
      end
      chk("t5_acc_cleared", acc0, 0);
      push(0, 16'd4, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd1, 1'b0);
      chk("t5_acc", acc0, 4);
      idle(0, 1);

      // 6: N_TERMS=1, single-term groups with gaps
      push(2, 16'd7, 1'b0);
      idle(2, 2);
      send(2, 8'd7, 1'b0);
      chk("t6_first_valid", av[2], 1);
      chk("t6_first_acc", acc2, 7);
      idle(2, 3);
      push(2, 16'd9, 1'b0);
      send(2, 8'd9, 1'b0);
      chk("t6_second_valid", av[2], 1);
      chk("t6_second_acc", acc2, 9);
      idle(2, 2);

      // Drain: every expected result must have been observed.
      for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      chk("drain_q2", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
